// File: rtl/vram_scanout_scheduler.sv
// Shares one single-port VRAM between a per-line scanout fetch into a ping-pong
// line buffer and a valid/ready host write port, and emits the 4-bpp pixel stream.
module vram_scanout_scheduler #(
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int V_MAX        = 524,
  parameter int ADDR_W       = 16,
  parameter int PIX_PER_WORD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       hpos,
  input  logic [15:0]       vpos,
  input  logic              display_on,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        pix,
  output logic              pix_on
);

  localparam int WORDS_PER_LINE = H_DISPLAY / PIX_PER_WORD;
  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [ADDR_W-1:0] row_addr, row_nxt;
  logic              lsel;
  logic              first_line, ftrig, start, issue, accept;
  logic              re_p1, sel_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [15:0]       linebuf [2][WORDS_PER_LINE];
  logic [IDX_W-1:0]  rd_word;
  logic [15:0]       rd_data;

  assign first_line = (vpos == 16'(V_MAX));
  assign ftrig      = (hpos == '0) && (first_line || (vpos < 16'(V_DISPLAY - 1)));
  assign accept     = host_valid && host_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ftrig) state_nxt = FETCH;
      FETCH:   if (idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so the read strobe and address are computed from
  // next-cycle values: mem_re is high exactly while the FSM sits in FETCH.
  always_comb begin
    start      = (state == IDLE) && ftrig;
    host_ready = (state == IDLE) && !ftrig;
    issue      = (state_nxt == FETCH);
    idx_nxt    = idx;
    if (start)               idx_nxt = '0;
    else if (state == FETCH) idx_nxt = idx + IDX_W'(1);
    row_nxt = row_addr;
    if (start) row_nxt = first_line ? fb_base : row_addr + ADDR_W'(WORDS_PER_LINE);
  end

  // Stage p0: memory command issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      row_addr  <= '0;
      lsel      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      re_p1     <= 1'b0;
      idx_p1    <= '0;
      sel_p1    <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      row_addr <= row_nxt;
      if (start) lsel <= first_line ? 1'b0 : ~vpos[0];
      mem_re <= issue;
      mem_we <= accept;
      if (issue)       mem_addr <= row_nxt + ADDR_W'(idx_nxt);
      else if (accept) mem_addr <= host_addr;
      if (accept) mem_wdata <= host_wdata;
      re_p1  <= mem_re;
      idx_p1 <= idx;
      sel_p1 <= lsel;
    end
  end

  // Stage p1: read data returns one cycle after mem_re
  always_ff @(posedge clk) begin
    if (re_p1) linebuf[sel_p1][idx_p1] <= mem_rdata;
  end

  assign rd_word = IDX_W'(hpos[9:2]);

  always_comb begin
    rd_data = '0;
    if (hpos[9:2] < 8'(WORDS_PER_LINE)) rd_data = linebuf[vpos[0]][rd_word];
  end

  // Pixel output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix    <= '0;
      pix_on <= 1'b0;
    end else begin
      pix_on <= display_on;
      pix    <= display_on ? rd_data[{hpos[1:0], 2'b00} +: 4] : 4'd0;
    end
  end

endmodule

// File: tb/tb_vram_scanout_scheduler.sv
// Scoreboard bench for vram_scanout_scheduler on a scaled-down raster:
// a reference model predicts memory traffic, host_ready and pixels.
module tb_vram_scanout_scheduler;

  localparam int H_DISPLAY = 64;
  localparam int V_DISPLAY = 12;
  localparam int V_MAX     = 15;
  localparam int H_TOTAL   = 80;
  localparam int WPL       = H_DISPLAY / 4;

  logic        clk, reset_n;
  logic [15:0] hpos, vpos;
  logic        display_on;
  logic [15:0] fb_base;
  logic        host_valid, host_ready;
  logic [15:0] host_addr, host_wdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic [3:0]  pix;
  logic        pix_on;

  vram_scanout_scheduler #(
    .H_DISPLAY(H_DISPLAY), .V_DISPLAY(V_DISPLAY), .V_MAX(V_MAX),
    .ADDR_W(16), .PIX_PER_WORD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .fb_base(fb_base),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix(pix), .pix_on(pix_on)
  );

  typedef struct { int cyc; bit we; logic [15:0] addr; logic [15:0] data; } op_t;
  typedef struct { int cyc; bit on; logic [3:0] val; bit known; } px_t;

  op_t         exp_ops[$];
  px_t         exp_pix[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] vram    [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] exp_buf [2][WPL];
  bit          buf_ok [2];
  logic [15:0] m_row;
  bit          m_sel;
  int          busy_end = -1;

  task automatic tally(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // VRAM behaviour: read data is valid exactly one cycle after mem_re
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= vram[mem_addr];
    else        mem_rdata <= 16'($urandom);
  end

  // Reference model: predicts host_ready now and the traffic/pixels of later cycles
  always @(negedge clk) begin
    bit  ft, er;
    int  tl, h, sel;
    px_t p;
    op_t o;
    ft = (hpos == 0) && ((vpos == V_MAX) || (vpos < V_DISPLAY - 1));
    if (!reset_n) begin
      if (busy_end >= cyc) buf_ok[m_sel] = 0;
      exp_ops.delete();
      exp_pix.delete();
      busy_end = -1;
      m_row = 16'h0;
    end
    er = !ft && (busy_end < cyc);
    tally(host_ready === er, $sformatf("host_ready cyc=%0d hpos=%0d vpos=%0d actual=%b required=%b",
          cyc, hpos, vpos, host_ready, er));
    if (reset_n) begin
      h = int'(hpos);
      sel = int'(vpos) % 2;
      p.cyc = cyc + 1; p.on = display_on; p.val = 4'd0; p.known = 1;
      if (display_on) begin
        p.known = buf_ok[sel];
        p.val = exp_buf[sel][h / 4][4 * (h % 4) +: 4];
      end
      exp_pix.push_back(p);
      if (ft && busy_end < cyc) begin
        tl = (vpos == V_MAX) ? 0 : int'(vpos) + 1;
        m_row = (tl == 0) ? fb_base : m_row + 16'(WPL);
        m_sel = bit'(tl % 2);
        for (int i = 0; i < WPL; i++) begin
          o.cyc = cyc + 1 + i; o.we = 0; o.addr = m_row + 16'(i); o.data = 16'h0;
          exp_ops.push_back(o);
          exp_buf[m_sel][i] = ref_mem[m_row + 16'(i)];
        end
        buf_ok[m_sel] = 1;
        busy_end = cyc + WPL + 1;
      end
      if (host_valid && er) begin
        o.cyc = cyc + 1; o.we = 1; o.addr = host_addr; o.data = host_wdata;
        exp_ops.push_back(o);
        ref_mem[host_addr] = host_wdata;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents memory traffic or pixels
  always @(negedge clk) begin
    op_t e;
    px_t p;
    if (reset_n) begin
      if (mem_re && mem_we)
        tally(0, $sformatf("re_we_overlap cyc=%0d actual=both required=exclusive", cyc));
      if (mem_re || mem_we) begin
        if (exp_ops.size() == 0 || exp_ops[0].cyc > cyc) begin
          tally(0, $sformatf("unexpected_op cyc=%0d actual re=%b we=%b addr=%h required=none",
                cyc, mem_re, mem_we, mem_addr));
        end else begin
          e = exp_ops.pop_front();
          tally((e.cyc == cyc) && (mem_we == e.we) && (mem_addr == e.addr) &&
                (!e.we || mem_wdata == e.data),
                $sformatf("mem_op cyc=%0d actual we=%b addr=%h data=%h required cyc=%0d we=%b addr=%h data=%h",
                cyc, mem_we, mem_addr, mem_wdata, e.cyc, e.we, e.addr, e.data));
        end
      end else if (exp_ops.size() > 0 && exp_ops[0].cyc <= cyc) begin
        e = exp_ops.pop_front();
        tally(0, $sformatf("missing_op cyc=%0d actual=idle required we=%b addr=%h", cyc, e.we, e.addr));
      end
      while (exp_pix.size() > 0 && exp_pix[0].cyc < cyc) void'(exp_pix.pop_front());
      if (exp_pix.size() > 0 && exp_pix[0].cyc == cyc) begin
        p = exp_pix.pop_front();
        tally(pix_on === p.on, $sformatf("pix_on cyc=%0d actual=%b required=%b", cyc, pix_on, p.on));
        if (p.known)
          tally(pix === p.val, $sformatf("pix cyc=%0d actual=%h required=%h", cyc, pix, p.val));
      end
    end
  end

  // Stimulus: raster timing, host traffic and directed events
  initial begin
    int hp, vp, frame, dir_mode, last_hp, last_vp, last_frame;
    bit acc, quiet;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      a = 16'($urandom);
      vram[i] = a;
      ref_mem[i] = a;
    end
    vram[16'h1000] = 16'h4321;
    ref_mem[16'h1000] = 16'h4321;
    reset_n = 0; hpos = 16'd1; vpos = 16'd1; display_on = 0;
    fb_base = 16'h1000; host_valid = 0; host_addr = 0; host_wdata = 0;
    repeat (3) @(negedge clk);
    tally(mem_re === 0 && mem_we === 0, $sformatf("reset_strobes actual re=%b we=%b required=0", mem_re, mem_we));
    tally(mem_addr === 16'h0 && mem_wdata === 16'h0,
          $sformatf("reset_bus actual addr=%h wdata=%h required=0", mem_addr, mem_wdata));
    tally(pix === 4'h0 && pix_on === 0, $sformatf("reset_pix actual pix=%h on=%b required=0", pix, pix_on));
    @(posedge clk); #1;
    reset_n = 1;
    hp = 0; vp = V_MAX; frame = 0; dir_mode = 0; acc = 0;
    last_hp = 0; last_vp = 0; last_frame = -1;
    hpos = 16'(hp); vpos = 16'(vp); display_on = 0;
    while (!(frame == 4 && vp == 1 && hp == 40) && cyc < 20000) begin
      @(negedge clk);
      acc = host_valid && host_ready;
      if (last_frame == 0 && last_vp == 0 && last_hp < 4)
        tally(pix === 4'(last_hp + 1), $sformatf("pix_order hpos=%0d actual=%h required=%0d", last_hp, pix, last_hp + 1));
      if (last_frame == 0 && last_vp == 0 && last_hp == H_DISPLAY)
        tally(pix === 4'h0, $sformatf("pix_blank actual=%h required=0", pix));
      if (dir_mode == 2 && (acc || hpos == 40)) begin
        tally(acc && hpos == WPL + 2, $sformatf("simul_accept actual hpos=%0d acc=%b required hpos=%0d",
              hpos, acc, WPL + 2));
        dir_mode = 0;
      end
      last_hp = hp; last_vp = vp; last_frame = frame;
      @(posedge clk); #1;
      hp++;
      if (hp == H_TOTAL) begin
        hp = 0;
        vp = (vp == V_MAX) ? 0 : vp + 1;
        if (vp == V_MAX) frame++;
      end
      if (frame == 1 && vp == 3 && hp == 30) fb_base = 16'h2000;
      if (frame == 2 && vp == 2 && hp == 11) reset_n = 1;
      quiet = (frame == 2 && vp == 2 && hp >= 5 && hp <= 13) || (frame == 4 && vp == 1 && hp >= 30);
      hpos = 16'(hp); vpos = 16'(vp);
      display_on = (hp < H_DISPLAY) && (vp < V_DISPLAY);
      if (frame == 1 && vp == 4 && hp == H_TOTAL - 1) begin
        host_valid = 0; dir_mode = 1;
      end else if (dir_mode == 1) begin
        host_valid = 1; host_addr = 16'h0ABC; host_wdata = 16'($urandom); dir_mode = 2;
      end else if (dir_mode == 2) begin
        host_valid = 1;
      end else if (quiet) begin
        host_valid = 0;
      end else if (!host_valid || acc) begin
        host_valid = bit'($urandom_range(0, 1));
        a = 16'($urandom_range(0, 16'h3FFF));
        host_addr = (a == 16'h1000) ? 16'h0FFF : a;
        host_wdata = 16'($urandom);
      end
      if (frame == 2 && vp == 2 && hp == 8) begin
        #2 reset_n = 0;
        #1;
        tally(mem_re === 0 && mem_we === 0, $sformatf("async_reset actual re=%b we=%b required=0", mem_re, mem_we));
        tally(host_ready === 1, $sformatf("ready_in_reset actual=%b required=1", host_ready));
      end
    end
    tally(cyc < 20000, $sformatf("run_bound actual cyc=%0d required <20000", cyc));
    repeat (2) @(negedge clk);
    tally(exp_ops.size() == 0, $sformatf("ops_drained actual=%0d required=0", exp_ops.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_scanout_scheduler.md
# vram_scanout_scheduler

Scheduler for the single-port video RAM behind the VGA timing generator. Each scanline it fetches the next visible line from VRAM into a ping-pong line buffer, and it grants all remaining memory cycles to a host write port using a valid/ready handshake. It also emits the registered 4-bpp pixel stream aligned to the timing generator's `hpos`/`vpos`/`display_on`.

## Interface
Parameters:
- `H_DISPLAY`, 640, visible pixels per line
- `V_DISPLAY`, 480, visible lines
- `V_MAX`, 524, last line index of frame
- `ADDR_W`, 16, VRAM word address width
- `PIX_PER_WORD`, 4, 4-bit pixels per 16-bit word; `WORDS_PER_LINE` = `H_DISPLAY`/`PIX_PER_WORD` (160)

Ports:
- `clk` in 1: single clock, shared with the timing generator
- `reset_n` in 1: asynchronous, active-low reset
- `hpos` in 16: timing generator horizontal position (≥ 0, used unsigned)
- `vpos` in 16: timing generator vertical position (≥ 0, used unsigned)
- `display_on` in 1: timing generator visible-area flag
- `fb_base` in `ADDR_W`: framebuffer base word address
- `host_valid` in 1: host write request
- `host_ready` out 1: host write accepted this cycle when `host_valid` is also high
- `host_addr` in `ADDR_W`: host write address
- `host_wdata` in 16: host write data
- `mem_addr` out `ADDR_W`: VRAM address, registered
- `mem_re` out 1: VRAM read strobe, registered
- `mem_we` out 1: VRAM write strobe, registered
- `mem_wdata` out 16: VRAM write data, registered
- `mem_rdata` in 16: read data, valid exactly 1 cycle after `mem_re`
- `pix` out 4: pixel value, registered
- `pix_on` out 1: `display_on` delayed by 1 cycle

## Operation
- **Fetch trigger** (`ftrig`): asserted when `hpos`==0 and either `vpos`==`V_MAX` (target line L=0) or `vpos` < `V_DISPLAY`-1 (target L=`vpos`+1). No fetch occurs on any other line.
- **Row address:**
  - When L=0, `row_addr` is loaded from `fb_base`. `fb_base` is sampled only at this point; changes at any other time take effect next frame.
  - For every other target line, `row_addr` += `WORDS_PER_LINE` at trigger.
- **FSM states:** IDLE, FETCH, DRAIN.
  - IDLE→FETCH on `ftrig`, whatever the host state.
  - FETCH: issue one read per cycle, `mem_addr`=`row_addr`+`idx`, `idx` 0..159. After `idx`==159, go to DRAIN.
  - DRAIN: one cycle to capture the last `mem_rdata`, then go to IDLE.
- **Read capture:** a 1-cycle delayed copy of (`mem_re`, `idx`, L[0]) writes `mem_rdata` into `linebuf[L[0]][idx]`.
- **Host port:**
  - `host_ready` = (state==IDLE) && !`ftrig`. It is combinational.
  - On accept, the next cycle drives `mem_we`=1, `mem_addr`=`host_addr`, `mem_wdata`=`host_wdata` for exactly one cycle. Back-to-back accepts are allowed.
  - `mem_re` and `mem_we` are never high in the same cycle.
- **Pixel path:**
  - The read side uses `linebuf[vpos[0]]`, word `hpos`[9:2], nibble `hpos`[1:0]. Nibble 0 is bits [3:0].
  - `pix` is 0 whenever `display_on` was 0.
  - The fetch for line L writes buffer L[0] while line L-1 reads the other buffer, so read and write never collide.
- **Reset:**
  - Outputs on reset: `mem_re`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `pix`=0, `pix_on`=0, state=IDLE, `idx`=0, `row_addr`=0.
  - `host_ready` follows its equation, i.e. 1 while `reset_n` is deasserted unless `ftrig`.
  - Line buffer contents are not reset.
  - Reset during FETCH aborts the fetch with no further `mem_re`. A pending host accept is dropped.

## Timing
- Trigger at cycle T (`hpos`=0): `mem_re` is high for cycles T+1..T+160, with addresses `row_addr`..`row_addr`+159. Line buffer writes occur at T+2..T+161. The FSM is back in IDLE at T+162.
- `host_ready` is low from T to T+161 inclusive (162 cycles). It is high on all other cycles of a line. There are no host blackouts during lines `V_DISPLAY`-1..`V_MAX`-1.
- Pixel latency: `pix`/`pix_on` at cycle t+1 reflect `hpos`/`vpos`/`display_on` at cycle t.
- Host write latency: accept at cycle t → `mem_we` at t+1.
- Simultaneous `host_valid` and `ftrig`: the fetch wins, `host_ready`=0, and the host holds its request.

## Test plan
- **Frame fetch:** `fb_base`=0x1000, run a full frame. At `vpos`=524,`hpos`=0, 160 reads 0x1000..0x109F. At `vpos`=0, reads 0x10A0..0x113F. At `vpos`=478, reads for line 479 at 0x1000+479·160. No reads on `vpos` 479..523.
- **Pixel order:** preload VRAM word 0x1000=0x4321. During line 0, `pix` sequence 1,2,3,4 on cycles `hpos`=0..3 +1. `pix`=0 while `display_on`=0.
- **Host contention:** hold `host_valid`=1 with addresses 0x0000..; `host_ready`=0 exactly for cycles `hpos`=0..161 of fetching lines. The writes appear one cycle after each accept and never overlap `mem_re`.
- **Simultaneous request:** assert `host_valid` first on a fetch-trigger cycle. It is not accepted, and is accepted at `hpos`=162.
- **Base change:** change `fb_base` to 0x2000 mid-frame. Current-frame addresses are unchanged; the next frame starts at 0x2000.
- **Reset mid-fetch:** pull `reset_n` low at `hpos`=50 of a fetch. `mem_re`=0 asynchronously. After release the state is IDLE, `host_ready` follows its equation, and the next trigger fetches normally.
